// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset/NOP constants and the {pc, inst}
// entry type used by the instruction fetch stage.
package inst_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // First fetch address after reset unless the instance overrides it.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    // addi x0, x0, 0 -- presented to ID whenever nothing valid is offered.
    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with a flush input.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop all entries (wins over push/pop)
//   push, push_data     write an entry
//   pop                 consume the head entry
//   head_data           current head (don't-care when empty)
//   empty, full, count  occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage of the RV64 pipeline. Owns the PC, issues in-order
// fetches to instruction memory, buffers returned words with their PCs and
// hands {pc, inst} to ID. An EX redirect flushes all wrong-path work.
//
// Build option: FETCH_BYPASS_EN -- when defined, a response arriving while
// the buffer is empty (and nothing is being killed) is forwarded to ID in the
// same cycle; it is buffered only if ID does not take it.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr fetch request channel
//   imem_rsp_valid, imem_rsp_data   in-order response, never backpressured
//   redirect_valid, redirect_pc     single-cycle PC redirect from EX
//   id_valid/ready, id_pc, id_inst  instruction hand-off to ID
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [63:0]  pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill_cnt;

    logic         credit_ok;
    logic         req_fire;
    logic         rsp_drop;
    logic         rsp_keep;
    logic         bypass;
    logic         id_fire;
    logic         buf_push;
    logic         buf_pop;
    logic         buf_empty;
    logic [CW-1:0] buf_count;
    fetch_entry_t buf_in;
    fetch_entry_t buf_head;
    logic [63:0]  pcq_head;

    logic          unused_buf_full;
    logic          unused_pcq_empty;
    logic          unused_pcq_full;
    logic [CW-1:0] unused_pcq_count;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outstanding requests plus buffered entries never exceed the buffer
    // depth, so every response that survives the kill count has a slot.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW + 1)'(FIFO_DEPTH);

    // rst_n gating keeps both valids low for the whole reset window.
    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response landing in the redirect cycle is wrong-path as well.
    assign rsp_drop = imem_rsp_valid && (redirect_valid || (kill_cnt != '0));
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_keep && buf_empty;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid = rst_n && !redirect_valid && (!buf_empty || bypass);
    assign id_fire  = id_valid && id_ready;
    assign buf_pop  = id_fire && !buf_empty;
    assign buf_push = rsp_keep && !(bypass && id_ready);

    assign buf_in.pc   = pcq_head;
    assign buf_in.inst = imem_rsp_data;

    always_comb begin
        id_pc   = '0;
        id_inst = INST_NOP;
        if (id_valid) begin
            if (bypass) begin
                id_pc   = pcq_head;
                id_inst = imem_rsp_data;
            end else begin
                id_pc   = buf_head.pc;
                id_inst = buf_head.inst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            kill_cnt    <= '0;
        end else if (redirect_valid) begin
            // No request goes out this cycle; every in-flight fetch is stale.
            pc          <= {redirect_pc[63:2], 2'b00};
            outstanding <= outstanding - CW'(imem_rsp_valid);
            kill_cnt    <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 64'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .head_data (buf_head),
        .empty     (buf_empty),
        .full      (unused_buf_full),
        .count     (buf_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .head_data (pcq_head),
        .empty     (unused_pcq_empty),
        .full      (unused_pcq_full),
        .count     (unused_pcq_count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_0000;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int          lat_min = 0;
    int          lat_max = 0;
    logic [63:0] mq_addr[$];
    int          mq_dly[$];

    always begin
        @(negedge clk);
        if (!rst_n) begin
            mq_addr.delete();
            mq_dly.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_addr);
            mq_dly.push_back(int'($urandom_range(lat_max, lat_min)));
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq_addr.size() > 0) begin
            if (mq_dly[0] == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(mq_addr.pop_front());
                void'(mq_dly.pop_front());
            end else begin
                mq_dly[0] = mq_dly[0] - 1;
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    // Program order: PCs advance by 4 from reset / redirect target. Every
    // accepted request on the current path is an expected ID output.
    logic [63:0] model_req_pc;
    logic [95:0] exp_q[$];
    logic [63:0] post_addrs[$];
    logic [63:0] post_ids[$];
    int          cyc = 0;
    int          req_fires = 0;
    int          id_fires = 0;
    int          total_ids = 0;
    int          first_req_cyc = -1;
    int          second_req_cyc = -1;
    int          first_id_cyc = -1;
    logic        rsp_at_redir = 1'b0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_req_wait = 1'b0;
    logic [63:0] prev_addr;

    always @(negedge clk) begin
        logic [95:0] e;
        cyc++;
        if (!rst_n) begin
            check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check_eq("rst_id_valid", 64'(id_valid), 64'd0);
            model_req_pc   = RST_PC;
            exp_q.delete();
            post_addrs.delete();
            post_ids.delete();
            req_fires      = 0;
            id_fires       = 0;
            first_req_cyc  = -1;
            second_req_cyc = -1;
            first_id_cyc   = -1;
            prev_hold      = 1'b0;
            prev_req_wait  = 1'b0;
        end else begin
            if (prev_hold && !redirect_valid) begin
                check_eq("hold_valid", 64'(id_valid), 64'd1);
                check_eq("hold_pc", id_pc, prev_pc);
                check_eq("hold_inst", 64'(id_inst), 64'(prev_inst));
            end
            if (prev_req_wait && !redirect_valid) begin
                check_eq("req_hold_valid", 64'(imem_req_valid), 64'd1);
                check_eq("req_hold_addr", imem_addr, prev_addr);
            end
            if (redirect_valid) begin
                check_eq("redir_no_req", 64'(imem_req_valid), 64'd0);
                check_eq("redir_no_id", 64'(id_valid), 64'd0);
                rsp_at_redir = imem_rsp_valid;
                exp_q.delete();
                post_addrs.delete();
                post_ids.delete();
                model_req_pc = {redirect_pc[63:2], 2'b00};
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    check_eq("req_addr", imem_addr, model_req_pc);
                    exp_q.push_back({model_req_pc, inst_of(model_req_pc)});
                    post_addrs.push_back(imem_addr);
                    model_req_pc = model_req_pc + 64'd4;
                    req_fires++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    else if (second_req_cyc < 0) second_req_cyc = cyc;
                end
                if (!id_valid) begin
                    check_eq("idle_inst", 64'(id_inst), 64'(INST_NOP));
                end else if (first_id_cyc < 0) begin
                    first_id_cyc = cyc;
                end
                if (id_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL id_unexpected actual=%h expected=none", id_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("id_pc", id_pc, e[95:32]);
                        check_eq("id_inst", 64'(id_inst), 64'(e[31:0]));
                    end
                    post_ids.push_back(id_pc);
                    id_fires++;
                    total_ids++;
                end
            end
            prev_hold     = id_valid && !id_ready && !redirect_valid;
            prev_pc       = id_pc;
            prev_inst     = id_inst;
            prev_req_wait = imem_req_valid && !imem_req_ready;
            prev_addr     = imem_addr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        // 1: straight-line fetch, 1-cycle memory, ID always ready
        lat_min = 0; lat_max = 0;
        id_ready = 1'b1; imem_req_ready = 1'b1;
        apply_reset();
        repeat (12) @(posedge clk);
        #1;
        check_eq("t1_latency", 64'(first_id_cyc - first_req_cyc), 64'(EXP_LAT));
        check_eq("t1_back_to_back", 64'(second_req_cyc - first_req_cyc), 64'd1);
        check_eq("t1_nreq", 64'(post_addrs.size() >= 3), 64'd1);
        if (post_addrs.size() >= 3) begin
            check_eq("t1_addr0", post_addrs[0], 64'h8000_0000);
            check_eq("t1_addr1", post_addrs[1], 64'h8000_0004);
            check_eq("t1_addr2", post_addrs[2], 64'h8000_0008);
        end
        check_eq("t1_id_progress", 64'(id_fires >= 5), 64'd1);
        if (post_ids.size() >= 1) check_eq("t1_id0", post_ids[0], 64'h8000_0000);

        // 2: decode stall right after reset (reset asserted mid-operation)
        id_ready = 1'b0;
        apply_reset();
        repeat (8) @(posedge clk);
        #1;
        check_eq("t2_req_credit", 64'(req_fires), 64'd2);
        check_eq("t2_req_idle", 64'(imem_req_valid), 64'd0);
        check_eq("t2_id_valid", 64'(id_valid), 64'd1);
        check_eq("t2_id_pc", id_pc, RST_PC);
        check_eq("t2_id_inst", 64'(id_inst), 64'(inst_of(RST_PC)));
        id_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t2_resume", 64'(id_fires >= 4), 64'd1);

        // 3: redirect with two requests outstanding, slow memory
        lat_min = 3; lat_max = 3;
        apply_reset();
        repeat (2) @(posedge clk);
        #1;
        pulse_redirect(64'h0000_0000_8000_1002);
        repeat (25) @(posedge clk);
        #1;
        check_eq("t3_have_req", 64'(post_addrs.size() >= 1), 64'd1);
        if (post_addrs.size() >= 1) check_eq("t3_addr", post_addrs[0], 64'h8000_1000);
        check_eq("t3_have_id", 64'(post_ids.size() >= 1), 64'd1);
        if (post_ids.size() >= 1) check_eq("t3_id", post_ids[0], 64'h8000_1000);

        // 4: redirect coinciding with a response and a would-be ID handshake
        lat_min = 0; lat_max = 0;
        apply_reset();
        repeat (2) @(posedge clk);
        #1;
        pulse_redirect(64'h0000_0000_9000_0000);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t4_rsp_coincide", 64'(rsp_at_redir), 64'd1);
        if (post_ids.size() >= 1) check_eq("t4_id", post_ids[0], 64'h9000_0000);
        check_eq("t4_have_id", 64'(post_ids.size() >= 1), 64'd1);

        // 5: request held under backpressure at the top of the address space
        apply_reset();
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        repeat (2) @(posedge clk);
        #1;
        check_eq("t5_stall_valid", 64'(imem_req_valid), 64'd1);
        check_eq("t5_stall_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t5_have_reqs", 64'(post_addrs.size() >= 3), 64'd1);
        if (post_addrs.size() >= 3) begin
            check_eq("t5_addr0", post_addrs[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check_eq("t5_addr1", post_addrs[1], 64'h0);
            check_eq("t5_addr2", post_addrs[2], 64'h4);
        end

        // 6: randomized traffic with redirects and one mid-run reset
        lat_min = 0; lat_max = 3;
        total_ids = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            id_ready       = ($urandom_range(3, 0) != 0);
            imem_req_ready = ($urandom_range(4, 0) != 0);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            if (!redirect_valid && $urandom_range(24, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = {$urandom, $urandom};
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rand_progress", 64'(total_ids > 300), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
